hex2decdigi_seq: RTL
====================

Name: hex2decdigi_seq

Overview:
Parametrised successor to the 6-bit two-digit converter. Converts an IN_W-bit unsigned binary value into DIGITS seven-segment digit codes using an iterative shift-and-add-3 (double-dabble) engine, one shift per clock. A valid/ready input handshake and a one-cycle result strobe let it sit between counter/timer logic and the display driver, for values wider than the fixed compare-chain block can handle.

Parameters:
IN_W, 16, width of binary input (>= 2)
DIGITS, 5, number of decimal digits produced (>= 1); digit 0 is units

Ports:
clock  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
hex  in  IN_W  binary value, sampled only on handshake
in_valid  in  1  source has a value
in_ready  out  1  block idle, can accept
out_valid  out  1  one-cycle strobe: digi/ovf updated this cycle
digi  out  DIGITS*7  digit i at [7i+6:7i], team segment encoding
ovf  out  1  value exceeds 10^DIGITS-1; valid with out_valid, held after

Behaviour:
- Segment codes (bit6..0): 0=0111111, 1=0011000, 2=1110110, 3=1111100, 4=1011001, 5=1101101, 6=1101111, 7=0111000, 8=1111111, 9=1111101, blank=0000000.
- Reset (async assert, sync release): state IDLE, digi all blank, ovf=0, out_valid=0, internal BCD/shift regs 0.
- in_ready = (state==IDLE), combinational from state; 1 out of reset.
- FSM IDLE -> SHIFT -> ENC -> IDLE.
- IDLE: on in_valid&&in_ready at edge E, load shift reg with hex, clear BCD and ovf accumulator, counter=IN_W-1, go SHIFT. Otherwise stay; digi/ovf hold.
- SHIFT: each cycle, for every BCD digit >= 5 add 3 (4-bit, no carry across digits), then shift {BCD, shift reg} left 1. Bit shifted out of top BCD digit ORs into ovf accumulator. IN_W cycles; on counter==0 go ENC.
- ENC: register digi from BCD digits (via encoder), ovf from accumulator; out_valid=1 in the cycle after ENC edge; go IDLE.
- Latency: handshake at edge E -> out_valid high during cycle after edge E+IN_W+1 (IN_W+1 cycles busy). in_ready returns high in same cycle as out_valid; back-to-back accept in that cycle is legal.
- in_valid while busy: ignored, no queueing; source must hold hex until handshake.
- ovf=1: all digi blank (overrides digits and blanking); ovf=0 otherwise.
- hex=0: all digits show 0 (subject to optional feature).
- Reset mid-SHIFT/ENC: conversion aborted, no out_valid, outputs to reset values.
- out_valid exactly one cycle per accepted input; never asserted without prior handshake.

Optional Feature:
HEX2DEC_LZ_BLANK_EN. Defined: leading-zero blanking in ENC - every digit above the most significant non-zero digit is blank; digit 0 always shown (0 -> "      0"). Undefined: all DIGITS always displayed with leading zeros. ovf blanking applies either way.

Decomposition:
- Package hex2dec_pkg: 7-bit segment constants SEG_0..SEG_9, SEG_BLANK; state enum encoding (IDLE/SHIFT/ENC, 2 bits).
- Sub-module seg7_enc: combinational 4-bit BCD -> 7-bit segment code, 10..15 -> blank; DIGITS instances via generate.
- Counter width $clog2(IN_W); BCD reg width 4*DIGITS.

Test Plan:
- Reset: rst_n low mid-SHIFT -> in_ready=1, out_valid=0, digi=0, ovf=0 immediately; no strobe after release.
- Default params, hex=65535 -> out_valid exactly 17 cycles after accept edge, digits(4..0)=6,5,5,3,5 codes, ovf=0.
- hex=0 -> all five digits = 0111111 (macro off); macro on -> digits 4..1 blank, digit 0 = 0111111.
- hex=1234, then hex=7 accepted in out_valid cycle -> two strobes 17 cycles apart; second digi = 0,0,0,0,7 (off) / blank x4,7 (on).
- IN_W=8, DIGITS=2: hex=99 -> 9,9 ovf=0; hex=100 -> ovf=1, digi all 0000000; hex=255 -> ovf=1.
- in_valid held high with changing hex during busy -> in_ready=0, only first value converted; out_valid count equals handshake count.

Source files
------------

// File: rtl/hex2dec_pkg.sv
// Shared constants for the sequential binary-to-seven-segment converter:
// segment codes (bit6..0) and the 2-bit FSM state encoding.
package hex2dec_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0011000;
  localparam logic [6:0] SEG_2     = 7'b1110110;
  localparam logic [6:0] SEG_3     = 7'b1111100;
  localparam logic [6:0] SEG_4     = 7'b1011001;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1101111;
  localparam logic [6:0] SEG_7     = 7'b0111000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111101;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ENC   = 2'd2;

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD digit to seven-segment code; codes 10..15 show blank.
module seg7_enc
  import hex2dec_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex2decdigi_seq.sv
// Iterative double-dabble converter: IN_W-bit binary -> DIGITS seven-segment codes.
// Define HEX2DEC_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module hex2decdigi_seq
  import hex2dec_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       hex,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DIGITS*7-1:0]   digi,
  output logic                  ovf
);

  localparam int CW = $clog2(IN_W);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(IN_W - 1);

  logic [1:0]          state_q, state_d;
  logic [IN_W-1:0]     sh_q, sh_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [DIGITS*7-1:0] digi_q, digi_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;

  logic [BW-1:0]       bcd_adj;
  logic [DIGITS*7-1:0] seg_raw;
  logic [DIGITS*7-1:0] enc_digi;
  logic [DIGITS-1:0]   show;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
      seg7_enc u_enc (
        .bcd (bcd_q[4*gi +: 4]),
        .seg (seg_raw[7*gi +: 7])
      );
      // Overflow wins over both the digit value and any leading-zero rule.
      assign enc_digi[7*gi +: 7] = (acc_q || !show[gi]) ? SEG_BLANK : seg_raw[7*gi +: 7];
    end
  endgenerate

`ifdef HEX2DEC_LZ_BLANK_EN
  logic [DIGITS-1:0] nz;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign nz[gi] = |bcd_q[4*gi +: 4];
      if (gi == 0) begin : g_units
        assign show[gi] = 1'b1;
      end else begin : g_upper
        assign show[gi] = |nz[DIGITS-1:gi];
      end
    end
  endgenerate
`else
  assign show = '1;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign digi      = digi_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    digi_d      = digi_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d    = hex;
          bcd_d   = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Any bit leaving the top digit means the value needs more digits.
        bcd_d = {bcd_adj[BW-2:0], sh_q[IN_W-1]};
        sh_d  = {sh_q[IN_W-2:0], 1'b0};
        acc_d = acc_q | bcd_adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = ST_ENC;
        end
      end
      ST_ENC: begin
        digi_d      = enc_digi;
        ovf_d       = acc_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      digi_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      digi_q      <= digi_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
